// File: rtl/jtag_gpio_pkg.sv
// Shared definitions for the virtual-JTAG GPIO bridge: opcodes, STATUS
// layout and the width helper used to size the data register.
package jtag_gpio_pkg;

    localparam int OP_BYPASS    = 0;
    localparam int OP_READ_IN   = 1;
    localparam int OP_WRITE_OUT = 2;
    localparam int OP_READ_OUT  = 3;
    localparam int OP_STATUS    = 4;

    localparam int STATUS_W     = 16;
    localparam int ST_LEN_ERR   = 0;
    localparam int ST_PAR_ERR   = 1;
    localparam int ST_WCNT_LSB  = 8;

    typedef enum logic [2:0] {
        K_BYPASS,
        K_READ_IN,
        K_WRITE_OUT,
        K_READ_OUT,
        K_STATUS
    } op_kind_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/jtag_sync2.sv
// Two-flop synchroniser bringing the asynchronous input bank into tck.
module jtag_sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    // Two back-to-back stages; cleared asynchronously with the bridge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
        end
    end

    assign dout = sync_reg;

endmodule

// File: rtl/jtag_gpio_bridge.sv
// Virtual-JTAG data-register endpoint giving host access to an input bank,
// an output bank and a status word. Optional even-parity protection of
// output-bank writes is enabled by defining JTAG_GPIO_PARITY_EN.
module jtag_gpio_bridge
    import jtag_gpio_pkg::*;
#(
    parameter int               IR_W    = 3,
    parameter int               IN_W    = 4,
    parameter int               OUT_W   = 8,
    parameter logic [OUT_W-1:0] RST_VAL = '0
) (
    input  logic             tck,
    input  logic             aclr,
    input  logic             tdi,
    input  logic [IR_W-1:0]  ir_in,
    input  logic             v_cdr,
    input  logic             v_sdr,
    input  logic             v_udr,
    input  logic             v_uir,
    input  logic [IN_W-1:0]  sw_in,
    output logic             tdo,
    output logic [OUT_W-1:0] led_out,
    output logic             led_stb,
    output logic             err
);

`ifdef JTAG_GPIO_PARITY_EN
    localparam int OUT_LEN = OUT_W + 1;
`else
    localparam int OUT_LEN = OUT_W;
`endif
    localparam int DR_W  = max3(IN_W, OUT_W + 1, STATUS_W);
    localparam int CNT_W = $clog2(DR_W + 2);

    op_kind_e         kind;
    logic [CNT_W-1:0] len;
    logic [DR_W-1:0]  sr_reg, sr_cap, sr_shift;
    logic [CNT_W-1:0] cnt_reg;
    logic             bypass_reg, udr_q_reg;
    logic [OUT_W-1:0] led_reg;
    logic             stb_reg, len_err_reg, par_err_reg;
    logic [7:0]       wcnt_reg;
    logic [IN_W-1:0]  sw_sync;
    logic [STATUS_W-1:0] status_word;
    logic             commit, len_ok, par_ok;

    jtag_sync2 #(.W(IN_W)) u_sync (
        .clk   (tck),
        .clr_n (aclr),
        .din   (sw_in),
        .dout  (sw_sync)
    );

    // Opcode decode and active shift length; unknown opcodes act as BYPASS.
    always_comb begin
        kind = K_BYPASS;
        len  = CNT_W'(1);
        if (ir_in == IR_W'(OP_READ_IN)) begin
            kind = K_READ_IN;
            len  = CNT_W'(IN_W);
        end else if (ir_in == IR_W'(OP_WRITE_OUT)) begin
            kind = K_WRITE_OUT;
            len  = CNT_W'(OUT_LEN);
        end else if (ir_in == IR_W'(OP_READ_OUT)) begin
            kind = K_READ_OUT;
            len  = CNT_W'(OUT_LEN);
        end else if (ir_in == IR_W'(OP_STATUS)) begin
            kind = K_STATUS;
            len  = CNT_W'(STATUS_W);
        end
    end

    // Capture value, zero-extended to the full register width.
    always_comb begin
        status_word = '0;
        status_word[ST_LEN_ERR] = len_err_reg;
        status_word[ST_PAR_ERR] = par_err_reg;
        status_word[ST_WCNT_LSB +: 8] = wcnt_reg;
        sr_cap = '0;
        case (kind)
            K_READ_IN:  sr_cap[IN_W-1:0] = sw_sync;
            K_READ_OUT: begin
                sr_cap[OUT_W-1:0] = led_reg;
`ifdef JTAG_GPIO_PARITY_EN
                sr_cap[OUT_W] = ^led_reg;
`endif
            end
            K_STATUS:   sr_cap[STATUS_W-1:0] = status_word;
            default:    sr_cap = '0;
        endcase
    end

    // Shift only the active LEN bits: tdi enters at LEN-1, bits above stay put.
    genvar gi;
    generate
        for (gi = 0; gi < DR_W; gi++) begin : g_shift
            if (gi == DR_W - 1) begin : g_top
                assign sr_shift[gi] = (int'(len) == gi + 1) ? tdi : sr_reg[gi];
            end else begin : g_mid
                assign sr_shift[gi] = (int'(len) == gi + 1) ? tdi :
                                      (int'(len) >  gi + 1) ? sr_reg[gi + 1] : sr_reg[gi];
            end
        end
    endgenerate

`ifdef JTAG_GPIO_PARITY_EN
    assign par_ok = ~^sr_reg[OUT_W:0];
`else
    assign par_ok = 1'b1;
`endif
    assign len_ok = (cnt_reg == len);
    assign commit = v_udr && !udr_q_reg && (kind == K_WRITE_OUT);

    // Data register, bypass bit, bit counter and update-edge detector.
    always_ff @(posedge tck or negedge aclr) begin
        if (!aclr) begin
            sr_reg     <= '0;
            bypass_reg <= 1'b0;
            cnt_reg    <= '0;
            udr_q_reg  <= 1'b0;
        end else begin
            if (v_cdr) begin
                sr_reg     <= sr_cap;
                bypass_reg <= 1'b0;
                cnt_reg    <= '0;
            end else if (v_sdr) begin
                sr_reg     <= sr_shift;
                bypass_reg <= tdi;
                if (cnt_reg != len + CNT_W'(1))
                    cnt_reg <= cnt_reg + CNT_W'(1);
            end
            // A new instruction abandons any partial shift and pending update.
            if (v_uir) begin
                cnt_reg   <= '0;
                udr_q_reg <= 1'b0;
            end else begin
                udr_q_reg <= v_udr;
            end
        end
    end

    // Commit handling: output bank, strobe, write counter and sticky errors.
    always_ff @(posedge tck or negedge aclr) begin
        if (!aclr) begin
            led_reg     <= RST_VAL;
            stb_reg     <= 1'b0;
            len_err_reg <= 1'b0;
            par_err_reg <= 1'b0;
            wcnt_reg    <= '0;
        end else begin
            stb_reg <= 1'b0;
            if (v_cdr && kind == K_STATUS) begin
                len_err_reg <= 1'b0;
                par_err_reg <= 1'b0;
            end
            if (commit) begin
                if (!len_ok) begin
                    len_err_reg <= 1'b1;
                end else if (!par_ok) begin
                    par_err_reg <= 1'b1;
                end else begin
                    led_reg  <= sr_reg[OUT_W-1:0];
                    stb_reg  <= 1'b1;
                    wcnt_reg <= wcnt_reg + 8'd1;
                end
            end
        end
    end

    assign tdo     = (kind == K_BYPASS) ? bypass_reg : sr_reg[0];
    assign led_out = led_reg;
    assign led_stb = stb_reg;
    assign err     = len_err_reg | par_err_reg;

endmodule

// File: tb/tb_jtag_gpio_bridge.sv
// Directed bench for jtag_gpio_bridge; honours JTAG_GPIO_PARITY_EN.
module tb_jtag_gpio_bridge;

`ifdef JTAG_GPIO_PARITY_EN
    localparam int OLEN = 9;
`else
    localparam int OLEN = 8;
`endif

    logic       tck = 1'b0;
    logic       aclr = 1'b0;
    logic       tdi = 1'b0;
    logic [2:0] ir_in = 3'd0;
    logic       v_cdr = 1'b0, v_sdr = 1'b0, v_udr = 1'b0, v_uir = 1'b0;
    logic [3:0] sw_in = 4'd0;
    logic       tdo;
    logic [7:0] led_out;
    logic       led_stb;
    logic       err;

    int total = 0;
    int bad   = 0;
    logic [31:0] got;
    logic [7:0]  led_first;
    int          stb_cnt;

    jtag_gpio_bridge #(
        .IR_W(3), .IN_W(4), .OUT_W(8), .RST_VAL(8'h5A)
    ) dut (
        .tck(tck), .aclr(aclr), .tdi(tdi), .ir_in(ir_in),
        .v_cdr(v_cdr), .v_sdr(v_sdr), .v_udr(v_udr), .v_uir(v_uir),
        .sw_in(sw_in), .tdo(tdo), .led_out(led_out), .led_stb(led_stb), .err(err)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge tck);
    endtask

    task automatic set_ir(input logic [2:0] op);
        ir_in = op;
        v_uir = 1'b1;
        tick();
        v_uir = 1'b0;
    endtask

    task automatic capture();
        v_cdr = 1'b1;
        tick();
        v_cdr = 1'b0;
    endtask

    // Shift n bits LSB first; tdo is sampled before each shifting edge.
    task automatic shift(input logic [31:0] data, input int n, output logic [31:0] res);
        res = '0;
        v_sdr = 1'b1;
        for (int i = 0; i < n; i++) begin
            tdi = data[i];
            res[i] = tdo;
            tick();
        end
        v_sdr = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic update(input int hold, output logic [7:0] first, output int stbs);
        stbs = 0;
        first = '0;
        v_udr = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (i == 0) first = led_out;
            stbs += int'(led_stb);
        end
        v_udr = 1'b0;
        tick();
        stbs += int'(led_stb);
    endtask

    function automatic logic [31:0] wr_word(input logic [7:0] v);
`ifdef JTAG_GPIO_PARITY_EN
        return {23'd0, ^v, v};
`else
        return {24'd0, v};
`endif
    endfunction

    task automatic read_status(output logic [31:0] res);
        set_ir(3'd4);
        capture();
        shift(32'd0, 16, res);
    endtask

    initial begin
        // 1. reset held, then released
        tick(); tick();
        chk("rst_led", {24'd0, led_out}, 32'h5A);
        chk("rst_tdo", {31'd0, tdo}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_stb", {31'd0, led_stb}, 32'd0);
        aclr = 1'b1;
        tick(); tick(); tick();
        chk("rel_led", {24'd0, led_out}, 32'h5A);
        chk("rel_stb", {31'd0, led_stb}, 32'd0);

        // 2. exact-length write with long update phase
        set_ir(3'd2);
        capture();
        shift(wr_word(8'hA5), OLEN, got);
        chk("wr_cap_zero", got, 32'd0);
        update(3, led_first, stb_cnt);
        chk("wr_led_edge", {24'd0, led_first}, 32'hA5);
        chk("wr_stb_once", stb_cnt, 32'd1);
        chk("wr_err", {31'd0, err}, 32'd0);
        read_status(got);
        chk("st_wcnt1", got & 32'hFFFF, 32'h0100);
        set_ir(3'd3);
        capture();
        shift(32'd0, OLEN, got);
        chk("readback", got, wr_word(8'hA5));

        // 3. short write, read-to-clear status, overlength write
        set_ir(3'd2);
        capture();
        shift(wr_word(8'h3C), OLEN - 1, got);
        update(1, led_first, stb_cnt);
        chk("short_led", {24'd0, led_out}, 32'hA5);
        chk("short_stb", stb_cnt, 32'd0);
        chk("short_err", {31'd0, err}, 32'd1);
        read_status(got);
        chk("st_lenerr", got & 32'hFFFF, 32'h0101);
        chk("err_cleared", {31'd0, err}, 32'd0);
        read_status(got);
        chk("st_clear", got & 32'hFFFF, 32'h0100);
        set_ir(3'd2);
        capture();
        shift(wr_word(8'h3C), OLEN + 1, got);
        update(1, led_first, stb_cnt);
        chk("long_led", {24'd0, led_out}, 32'hA5);
        chk("long_err", {31'd0, err}, 32'd1);
        read_status(got);
        chk("st_long", got & 32'hFFFF, 32'h0101);
        set_ir(3'd2);
        capture();
        shift(wr_word(8'h3C), OLEN, got);
        update(1, led_first, stb_cnt);
        chk("wr2_led", {24'd0, led_out}, 32'h3C);
        chk("wr2_stb", stb_cnt, 32'd1);
        read_status(got);
        chk("st_wcnt2", got & 32'hFFFF, 32'h0200);

        // 4. input bank through the synchroniser, bypass paths
        sw_in = 4'b1011;
        tick(); tick();
        set_ir(3'd1);
        capture();
        shift(32'd0, 4, got);
        chk("read_in", got, 32'hB);
        sw_in = 4'b0110;
        capture();
        shift(32'd0, 4, got);
        chk("read_in_late", got, 32'hB);
        capture();
        shift(32'd0, 4, got);
        chk("read_in_new", got, 32'h6);
        set_ir(3'd0);
        capture();
        shift(32'b101, 3, got);
        chk("bypass", got, 32'b010);
        set_ir(3'd7);
        capture();
        shift(32'b11, 2, got);
        chk("bypass_op7", got, 32'b10);

        // 5. interrupted shift, then reset mid-shift
        set_ir(3'd2);
        capture();
        shift(wr_word(8'hF0), 4, got);
        set_ir(3'd2);
        update(1, led_first, stb_cnt);
        chk("uir_led", {24'd0, led_out}, 32'h3C);
        chk("uir_stb", stb_cnt, 32'd0);
        chk("uir_err", {31'd0, err}, 32'd1);
        set_ir(3'd3);
        capture();
        shift(32'h7, 3, got);
        chk("mid_tdo_bits", got, 32'b100);
        chk("mid_tdo", {31'd0, tdo}, 32'd1);
        aclr = 1'b0;
        #1;
        chk("arst_led", {24'd0, led_out}, 32'h5A);
        chk("arst_tdo", {31'd0, tdo}, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        tick();
        aclr = 1'b1;
        tick();
        read_status(got);
        chk("arst_status", got & 32'hFFFF, 32'h0000);

`ifdef JTAG_GPIO_PARITY_EN
        // 6. parity-protected writes
        set_ir(3'd2);
        capture();
        shift(32'h003, 9, got);
        update(1, led_first, stb_cnt);
        chk("par_ok_led", {24'd0, led_out}, 32'h03);
        chk("par_ok_stb", stb_cnt, 32'd1);
        set_ir(3'd2);
        capture();
        shift(32'h007, 9, got);
        update(1, led_first, stb_cnt);
        chk("par_bad_led", {24'd0, led_out}, 32'h03);
        chk("par_bad_err", {31'd0, err}, 32'd1);
        read_status(got);
        chk("st_parerr", got & 32'hFFFF, 32'h0102);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
